ecc_scrubber: RTL and testbench

ECC_SCRUBBER -- requirements
Module: ecc_scrubber

---
 rtl/ecc_scrubber.sv | 124 ++++++++++++
 tb/tb_ecc_scrubber.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrubber.sv
// Background scrubber for an ECC-protected RAM: walks every address once per pass,
// writes back the corrected word and tallies uncorrectable (double-bit) errors.
module ecc_scrubber #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_hold,
  output logic                  o_en,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_din,
  input  logic [DATA_WIDTH-1:0] i_dout,
  input  logic                  i_error,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_err_cnt,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned ERR_W = 16;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ERR_W-1:0]      ERR_MAX   = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state, state_nx;
  logic [CNT_W-1:0]      lat_cnt, lat_cnt_nx;
  logic [ADDR_WIDTH-1:0] addr_nx, first_nx;
  logic [DATA_WIDTH-1:0] din_nx;
  logic [ERR_W-1:0]      err_nx;
  logic                  en_nx, we_nx, busy_nx, done_nx;

  // State and all outputs registered; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      lat_cnt          <= '0;
      o_addr           <= '0;
      o_din            <= '0;
      o_err_cnt        <= '0;
      o_first_err_addr <= '0;
      o_en             <= 1'b0;
      o_we             <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      state            <= state_nx;
      lat_cnt          <= lat_cnt_nx;
      o_addr           <= addr_nx;
      o_din            <= din_nx;
      o_err_cnt        <= err_nx;
      o_first_err_addr <= first_nx;
      o_en             <= en_nx;
      o_we             <= we_nx;
      o_busy           <= busy_nx;
      o_done           <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    addr_nx    = o_addr;
    din_nx     = o_din;
    err_nx     = o_err_cnt;
    first_nx   = o_first_err_addr;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nx = S_READ;
          addr_nx  = '0;
          err_nx   = '0;
          first_nx = '0;
        end
      end
      S_READ: begin
        state_nx   = S_WAIT;
        lat_cnt_nx = CNT_W'(RD_LATENCY);
      end
      S_WAIT: begin
        lat_cnt_nx = lat_cnt - CNT_W'(1);
        // Last latency cycle: read data is valid now
        if (lat_cnt == CNT_W'(1)) begin
          if (i_error) begin
            state_nx = S_NEXT;
            if (o_err_cnt != ERR_MAX) err_nx = o_err_cnt + ERR_W'(1);
            if (o_err_cnt == '0)      first_nx = o_addr;
          end else begin
            state_nx = S_WRITE;
            din_nx   = i_dout;
          end
        end
      end
      S_WRITE: state_nx = S_NEXT;
      S_NEXT: begin
        if (o_addr == ADDR_LAST) begin
          state_nx = S_DONE;
        end else if (!i_hold) begin
          state_nx = S_READ;
          addr_nx  = o_addr + ADDR_WIDTH'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    en_nx   = (state_nx == S_READ) || (state_nx == S_WRITE);
    we_nx   = (state_nx == S_WRITE);
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_DONE);
  end

endmodule

// File: tb/tb_ecc_scrubber.sv
// Scoreboard bench for ecc_scrubber: a RD_LATENCY=1 instance with a fault-injecting RAM
// model and a RD_LATENCY=3 instance with a clean RAM model.
module tb_ecc_scrubber;

  localparam int unsigned NW = 16;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct packed {
    logic [15:0] cycles;
    logic [15:0] err;
    logic [3:0]  first;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 1'b0, hold_a = 1'b0, start_b = 1'b0;

  logic       a_en, a_we, a_busy, a_done, a_err_i;
  logic [3:0] a_addr, a_first;
  logic [7:0] a_din, a_dout;
  logic [15:0] a_err;
  logic       b_en, b_we, b_busy, b_done, b_err_i;
  logic [3:0] b_addr, b_first;
  logic [7:0] b_din, b_dout;
  logic [15:0] b_err;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int start_cyc_a = 0, start_cyc_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  txn_t  q_a[$], q_b[$];
  done_t qd_a[$], qd_b[$];

  logic [7:0] mem_a[NW], flip_a[NW], flip_cfg[NW];
  logic       dbl_a[NW], dbl_cfg[NW];
  logic       init_req = 1'b0;
  logic [8:0] pa = 9'h0;
  logic [8:0] pb[3];
  logic       prev_en_a = 1'b0, prev_en_b = 1'b0;

  ecc_scrubber #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_hold(hold_a),
    .o_en(a_en), .o_we(a_we), .o_addr(a_addr), .o_din(a_din),
    .i_dout(a_dout), .i_error(a_err_i), .o_busy(a_busy), .o_done(a_done),
    .o_err_cnt(a_err), .o_first_err_addr(a_first));

  ecc_scrubber #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_hold(1'b0),
    .o_en(b_en), .o_we(b_we), .o_addr(b_addr), .o_din(b_din),
    .i_dout(b_dout), .i_error(b_err_i), .o_busy(b_busy), .o_done(b_done),
    .o_err_cnt(b_err), .o_first_err_addr(b_first));

  assign a_dout  = pa[7:0];
  assign a_err_i = pa[8];
  assign b_dout  = pb[2][7:0];
  assign b_err_i = pb[2][8];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM A: mem holds corrected data, raw cell = mem ^ flip; read data valid one cycle later
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < NW; i++) begin
        mem_a[i]  <= 8'(8'hA0 + i);
        flip_a[i] <= flip_cfg[i];
        dbl_a[i]  <= dbl_cfg[i];
      end
    end else if (a_en && a_we) begin
      mem_a[a_addr]  <= a_din;
      flip_a[a_addr] <= 8'h00;
    end
    if (a_en && !a_we) pa <= dbl_a[a_addr] ? 9'h1EE : {1'b0, mem_a[a_addr]};
    else               pa <= 9'h000;
  end

  // RAM B: clean contents 0x30+addr, three-cycle read pipeline, zero when not reading
  always @(posedge clk) begin
    pb[0] <= (b_en && !b_we) ? {1'b0, 8'(8'h30 + b_addr)} : 9'h000;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic fail_line(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h, required nothing", name, act);
  endtask

  // Monitors: pop expected port activity and pass-end results whenever the DUT shows them
  always @(negedge clk) begin : mon_a
    txn_t e;
    done_t d;
    if (a_en) begin
      chk("a_en_gap", 32'(prev_en_a), 32'd0);
      if (q_a.size() == 0) fail_line("a_unexpected_txn", {27'd0, a_we, a_addr});
      else begin
        e = q_a.pop_front();
        chk("a_we", 32'(a_we), 32'(e.we));
        chk("a_addr", 32'(a_addr), 32'(e.addr));
        if (e.we) chk("a_din", 32'(a_din), 32'(e.data));
      end
    end
    prev_en_a = a_en;
    if (a_done) begin
      done_cnt_a++;
      if (qd_a.size() == 0) fail_line("a_unexpected_done", 32'(cyc));
      else begin
        d = qd_a.pop_front();
        chk("a_pass_cycles", 32'(cyc - start_cyc_a), 32'(d.cycles));
        chk("a_err_cnt", 32'(a_err), 32'(d.err));
        chk("a_first_err", 32'(a_first), 32'(d.first));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    txn_t e;
    done_t d;
    if (b_en) begin
      chk("b_en_gap", 32'(prev_en_b), 32'd0);
      if (q_b.size() == 0) fail_line("b_unexpected_txn", {27'd0, b_we, b_addr});
      else begin
        e = q_b.pop_front();
        chk("b_we", 32'(b_we), 32'(e.we));
        chk("b_addr", 32'(b_addr), 32'(e.addr));
        if (e.we) chk("b_din", 32'(b_din), 32'(e.data));
      end
    end
    prev_en_b = b_en;
    if (b_done) begin
      done_cnt_b++;
      if (qd_b.size() == 0) fail_line("b_unexpected_done", 32'(cyc));
      else begin
        d = qd_b.pop_front();
        chk("b_pass_cycles", 32'(cyc - start_cyc_b), 32'(d.cycles));
        chk("b_err_cnt", 32'(b_err), 32'(d.err));
      end
    end
  end

  task automatic load_img(input int e1, input int e2, input int f_addr, input logic [7:0] f_mask);
    for (int i = 0; i < NW; i++) begin
      flip_cfg[i] = (i == f_addr) ? f_mask : 8'h00;
      dbl_cfg[i]  = (i == e1) || (i == e2);
    end
    @(posedge clk); #1 init_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0;
  endtask

  // Expected A traffic for addresses 0..last; double-error words get no write-back
  task automatic push_a(input int last, input bit read_only_last, input bit with_done,
                        input int cycles, input int err, input int first);
    for (int i = 0; i <= last; i++) begin
      q_a.push_back('{1'b0, 4'(i), 8'h00});
      if (!dbl_cfg[i] && !(read_only_last && i == last))
        q_a.push_back('{1'b1, 4'(i), 8'(8'hA0 + i)});
    end
    if (with_done) qd_a.push_back('{16'(cycles), 16'(err), 4'(first)});
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1; start_cyc_a = cyc;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int n0 = done_cnt_a;
    for (int k = 0; k < 3000 && done_cnt_a == n0; k++) @(posedge clk);
    if (done_cnt_a == n0) fail_line("a_done_timeout", 32'(cyc));
    #1;
  endtask

  task automatic wait_read_a(input logic [3:0] addr);
    bit found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (a_en && !a_we && a_addr == addr) found = 1'b1;
    end
    if (!found) fail_line("a_read_timeout", 32'(addr));
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin flip_cfg[i] = 8'h00; dbl_cfg[i] = 1'b0; end
    for (int i = 0; i < 3; i++) pb[i] = 9'h000;

    // Reset, with a start request coinciding with reset that must be dropped
    repeat (3) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start_a = 1'b0;
    chk("rst_a_en", 32'(a_en), 32'd0);
    chk("rst_a_addr", 32'(a_addr), 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    chk("start_in_rst_ignored", 32'(a_busy), 32'd0);

    // Clean pass: 16 read/write pairs, done 65 cycles after start
    load_img(-1, -1, -1, 8'h00);
    push_a(15, 1'b0, 1'b1, 65, 0, 0);
    pulse_start_a();
    wait_done_a();

    // Single-bit fault at 5: corrected word written back cleans the raw cell
    load_img(-1, -1, 5, 8'h04);
    chk("raw5_before", 32'(mem_a[5] ^ flip_a[5]), 32'h0000_00A1);
    push_a(15, 1'b0, 1'b1, 65, 0, 0);
    pulse_start_a();
    wait_done_a();
    chk("raw5_after", 32'(mem_a[5] ^ flip_a[5]), 32'h0000_00A5);

    // Double errors at 3 and 9: no write-back there, count 2, first at 3
    load_img(3, 9, -1, 8'h00);
    push_a(15, 1'b0, 1'b1, 63, 2, 3);
    pulse_start_a();
    wait_done_a();
    repeat (5) @(posedge clk); #1;
    chk("err_cnt_hold", 32'(a_err), 32'd2);
    chk("first_err_hold", 32'(a_first), 32'd3);

    // Hold from WAIT of address 7 for 12 cycles: NEXT stalls 10 extra cycles
    load_img(-1, -1, -1, 8'h00);
    push_a(15, 1'b0, 1'b1, 75, 0, 0);
    pulse_start_a();
    wait_read_a(4'd7);
    hold_a = 1'b1;
    repeat (12) @(posedge clk);
    #1 hold_a = 1'b0;
    wait_done_a();

    // Reset in WAIT of address 6 after a double error at 2
    load_img(2, -1, -1, 8'h00);
    push_a(6, 1'b1, 1'b0, 0, 0, 0);
    pulse_start_a();
    wait_read_a(4'd6);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_en", 32'(a_en), 32'd0);
    chk("mid_rst_we", 32'(a_we), 32'd0);
    chk("mid_rst_addr", 32'(a_addr), 32'd0);
    chk("mid_rst_din", 32'(a_din), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_done", 32'(a_done), 32'd0);
    chk("mid_rst_err", 32'(a_err), 32'd0);
    chk("mid_rst_first", 32'(a_first), 32'd0);
    chk("mid_rst_queue", 32'(q_a.size()), 32'd0);

    // Restart after reset begins again at address 0
    load_img(-1, -1, -1, 8'h00);
    push_a(15, 1'b0, 1'b1, 65, 0, 0);
    pulse_start_a();
    wait_done_a();

    // RD_LATENCY=3 instance: second start while busy is ignored, single done at 97
    for (int i = 0; i < NW; i++) begin
      q_b.push_back('{1'b0, 4'(i), 8'h00});
      q_b.push_back('{1'b1, 4'(i), 8'(8'h30 + i)});
    end
    qd_b.push_back('{16'd97, 16'd0, 4'd0});
    @(posedge clk); #1 start_b = 1'b1; start_cyc_b = cyc;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (10) @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int k = 0; k < 3000 && done_cnt_b == 0; k++) @(posedge clk);
    if (done_cnt_b == 0) fail_line("b_done_timeout", 32'(cyc));
    repeat (30) @(posedge clk); #1;
    chk("b_done_count", 32'(done_cnt_b), 32'd1);
    chk("b_busy_after", 32'(b_busy), 32'd0);

    chk("q_a_empty", 32'(q_a.size()), 32'd0);
    chk("qd_a_empty", 32'(qd_a.size()), 32'd0);
    chk("q_b_empty", 32'(q_b.size()), 32'd0);
    chk("qd_b_empty", 32'(qd_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
